metronome_gen: RTL

METRONOME_GEN -- requirements
Module: metronome_gen

---
 rtl/metronome_gen.sv | 88 ++++++++
 1 files changed

// File: rtl/metronome_gen.sv
// metronome_gen: beat square-wave generator with bar tracking and request-driven tempo
// Optional downbeat accent output enabled by defining METRONOME_ACCENT_EN.
module metronome_gen #(
  parameter int PERIOD_INIT   = 6000000,
  parameter int PERIOD_MIN    = 1200000,
  parameter int PERIOD_MAX    = 24000000,
  parameter int PERIOD_STEP   = 600000,
  parameter int BEATS_PER_BAR = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic       stop,
  input  logic       tempo_up,
  input  logic       tempo_down,
  output logic       metronome,
  output logic [2:0] beat_idx,
  output logic       bar_start,
  output logic       running,
  output logic       accent
);
  localparam logic [25:0] P_INIT = 26'(PERIOD_INIT);
  localparam logic [25:0] P_MIN  = 26'(PERIOD_MIN);
  localparam logic [25:0] P_MAX  = 26'(PERIOD_MAX);
  localparam logic [25:0] P_STEP = 26'(PERIOD_STEP);
  localparam logic [2:0]  B_LAST = 3'(BEATS_PER_BAR - 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t      state;
  logic [25:0] cnt;
  logic [25:0] period;
  logic [25:0] pending;
  logic [25:0] pending_nx;
  logic [2:0]  beat_nx;
  logic        wrap;
  // saturating tempo update; simultaneous up/down cancel out
  always_comb begin
    pending_nx = tempo_up && !tempo_down ? (pending < P_MIN + P_STEP ? P_MIN : pending - P_STEP) :
                 tempo_down && !tempo_up ? (pending > P_MAX - P_STEP ? P_MAX : pending + P_STEP) :
                 pending;
    wrap       = cnt == period - 26'd1;
    beat_nx    = beat_idx == B_LAST ? 3'd0 : beat_idx + 3'd1;
  end
  // run/idle FSM with beat counter; period only reloads at a beat boundary or on start
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      period    <= P_INIT;
      pending   <= P_INIT;
      beat_idx  <= '0;
      metronome <= 1'b0;
      bar_start <= 1'b0;
      running   <= 1'b0;
    end else begin
      pending <= pending_nx;
      if (state == IDLE) begin
        metronome <= 1'b0;
        bar_start <= 1'b0;
        if (start && !stop) begin
          state    <= RUN;
          running  <= 1'b1;
          cnt      <= '0;
          beat_idx <= '0;
          period   <= pending;
        end
      end else if (stop) begin
        state     <= IDLE;
        running   <= 1'b0;
        metronome <= 1'b0;
        bar_start <= 1'b0;
        cnt       <= '0;
      end else begin
        metronome <= cnt < (period >> 1);
        bar_start <= cnt == 26'd0 && beat_idx == 3'd0;
        cnt       <= wrap ? 26'd0 : cnt + 26'd1;
        if (wrap) begin
          beat_idx <= beat_nx;
          period   <= pending;
        end
      end
    end
  end
`ifdef METRONOME_ACCENT_EN
  assign accent = metronome && beat_idx == 3'd0;
`else
  assign accent = 1'b0;
`endif
endmodule
